// File: rtl/puf_meas_ctrl.sv
// Ring-oscillator PUF measurement sequencer: settles, counts and compares RESP_BITS oscillator pairs.
// Optional tie flags are enabled by defining PUF_TIE_FLAG_EN (adds the tie_mask output).
module puf_meas_ctrl #(
    parameter int SEL_W     = 5,
    parameter int CNT_W     = 8,
    parameter int RESP_BITS = 8,
    parameter int WINDOW    = 200,
    parameter int SETTLE    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [SEL_W-1:0]     challenge,
    input  logic                 ro_a,
    input  logic                 ro_b,
    output logic                 ro_en,
    output logic [SEL_W-1:0]     sel_a,
    output logic [SEL_W-1:0]     sel_b,
    output logic                 busy,
    output logic                 done,
    output logic [RESP_BITS-1:0] response
`ifdef PUF_TIE_FLAG_EN
    ,
    output logic [RESP_BITS-1:0] tie_mask
`endif
);

    // state     | meaning
    // S_IDLE    | waiting for start
    // S_SETTLE  | oscillators enabled, counters held at 0
    // S_COUNT   | counting synchronized rising edges over the window
    // S_COMPARE | write response[k], advance to the next pair or finish
    // S_DONE    | one-cycle completion pulse
    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_COUNT, S_COMPARE, S_DONE} state_t;

    localparam int K_W   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int T_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int T_W   = ($clog2(T_MAX) > 0) ? $clog2(T_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t               r_state;
    state_t               w_next;
    logic [T_W-1:0]       r_tmr;
    logic [K_W-1:0]       r_k;
    logic [CNT_W-1:0]     r_cnt_a;
    logic [CNT_W-1:0]     r_cnt_b;
    logic [2:0]           r_sync_a;
    logic [2:0]           r_sync_b;
    logic [SEL_W-1:0]     r_sel_a;
    logic [SEL_W-1:0]     r_sel_b;
    logic [RESP_BITS-1:0] r_resp;
    logic                 w_tmr_tc;
    logic                 w_last_bit;
    logic                 w_accept;
    logic                 w_rise_a;
    logic                 w_rise_b;

    assign w_tmr_tc   = (r_tmr == '0);
    assign w_last_bit = (r_k == K_W'(RESP_BITS - 1));
    assign w_accept   = (r_state == S_IDLE) && start;
    // [1] is the second synchronizer stage, [2] the history flop
    assign w_rise_a   = r_sync_a[1] & ~r_sync_a[2];
    assign w_rise_b   = r_sync_b[1] & ~r_sync_b[2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        ro_en  = 1'b0;
        busy   = 1'b1;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_SETTLE;
            end
            S_SETTLE: begin
                ro_en = 1'b1;
                if (w_tmr_tc) w_next = S_COUNT;
            end
            S_COUNT: begin
                ro_en = 1'b1;
                if (w_tmr_tc) w_next = S_COMPARE;
            end
            S_COMPARE: w_next = w_last_bit ? S_DONE : S_SETTLE;
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmr <= '0;
        end else if (w_accept || (r_state == S_COMPARE && !w_last_bit)) begin
            r_tmr <= T_W'(SETTLE - 1);
        end else if (r_state == S_SETTLE && w_tmr_tc) begin
            r_tmr <= T_W'(WINDOW - 1);
        end else if (!w_tmr_tc) begin
            r_tmr <= r_tmr - T_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync_a <= '0;
            r_sync_b <= '0;
        end else begin
            r_sync_a <= {r_sync_a[1:0], ro_a};
            r_sync_b <= {r_sync_b[1:0], ro_b};
        end
    end

    // Counters are zero outside COUNT, so COMPARE sees the final window totals
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else if (r_state == S_COUNT) begin
            if (w_rise_a && r_cnt_a != CNT_MAX) r_cnt_a <= r_cnt_a + CNT_W'(1);
            if (w_rise_b && r_cnt_b != CNT_MAX) r_cnt_b <= r_cnt_b + CNT_W'(1);
        end else begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_k     <= '0;
            r_sel_a <= '0;
            r_sel_b <= '0;
            r_resp  <= '0;
        end else if (w_accept) begin
            r_k     <= '0;
            r_sel_a <= challenge;
            r_sel_b <= challenge + SEL_W'(1);
            r_resp  <= '0;
        end else if (r_state == S_COMPARE) begin
            r_resp[r_k] <= (r_cnt_a > r_cnt_b);
            if (!w_last_bit) begin
                r_k     <= r_k + K_W'(1);
                r_sel_a <= r_sel_a + SEL_W'(2);
                r_sel_b <= r_sel_b + SEL_W'(2);
            end
        end
    end

`ifdef PUF_TIE_FLAG_EN
    logic [RESP_BITS-1:0] r_tie;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                      r_tie <= '0;
        else if (w_accept)              r_tie <= '0;
        else if (r_state == S_COMPARE)  r_tie[r_k] <= (r_cnt_a == r_cnt_b);
    end

    assign tie_mask = r_tie;
`endif

    assign sel_a    = r_sel_a;
    assign sel_b    = r_sel_b;
    assign response = r_resp;

endmodule

// File: tb/tb_puf_meas_ctrl.sv
// Self-checking bench for puf_meas_ctrl: timing/select/response model plus literal pins.
// Runs a CNT_W=8 and a CNT_W=2 instance side by side on the same stimulus.
module tb_puf_meas_ctrl;

    localparam int S   = 2;
    localparam int W   = 16;
    localparam int RB  = 4;
    localparam int PER = S + W + 1;
    localparam int LAT = RB * PER + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [4:0] challenge = '0;
    logic       ro_a = 1'b0;
    logic       ro_b = 1'b0;
    logic       ro_en, ro_en2, busy, busy2, done, done2;
    logic [4:0] sel_a, sel_b, sel_a2, sel_b2;
    logic [3:0] response, response2;
`ifdef PUF_TIE_FLAG_EN
    logic [3:0] tie_mask, tie_mask2;
`endif

    puf_meas_ctrl #(.SEL_W(5), .CNT_W(8), .RESP_BITS(RB), .WINDOW(W), .SETTLE(S)) dut (
        .clk(clk), .reset(reset), .start(start), .challenge(challenge),
        .ro_a(ro_a), .ro_b(ro_b), .ro_en(ro_en), .sel_a(sel_a), .sel_b(sel_b),
        .busy(busy), .done(done), .response(response)
`ifdef PUF_TIE_FLAG_EN
        , .tie_mask(tie_mask)
`endif
    );

    puf_meas_ctrl #(.SEL_W(5), .CNT_W(2), .RESP_BITS(RB), .WINDOW(W), .SETTLE(S)) dut2 (
        .clk(clk), .reset(reset), .start(start), .challenge(challenge),
        .ro_a(ro_a), .ro_b(ro_b), .ro_en(ro_en2), .sel_a(sel_a2), .sel_b(sel_b2),
        .busy(busy2), .done(done2), .response(response2)
`ifdef PUF_TIE_FLAG_EN
        , .tie_mask(tie_mask2)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int pa = 4;
    int pb = 8;

    bit         m_active = 1'b0;
    int         m_t0 = 0;
    int         m_ch = 0;
    logic [3:0] m_final, m_final2, m_tie, m_tie2;
    logic [3:0] m_hold = '0, m_hold2 = '0, m_tie_hold = '0, m_tie_hold2 = '0;
    int         n_done = 0;
    int         done_c = 0;
    int         obs_sel[RB];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Edges in a window that is a whole number of periods, clipped at the counter ceiling
    function automatic int edges(input int per, input int cw);
        int n;
        int mx;
        n  = W / per;
        mx = (1 << cw) - 1;
        return (n > mx) ? mx : n;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ro_a = ((cyc % pa) < (pa / 2));
        ro_b = ((cyc % pb) < (pb / 2));
    end

    always begin
        int c, bi, p;
        logic [3:0] mask;
        @(posedge clk);
        #1;
        if (!reset) begin
            if (m_active) begin
                c = cyc - m_t0;
                if (c >= 1 && c <= LAT) begin
                    mask = '0;
                    for (int j = 0; j < RB; j++) if (PER * (j + 1) < c) mask[j] = 1'b1;
                    chk("busy", busy, 1);
                    chk("done", done, (c == LAT) ? 1 : 0);
                    chk("response", response, m_final & mask);
                    chk("response_cnt2", response2, m_final2 & mask);
                    chk("done_cnt2", done2, (c == LAT) ? 1 : 0);
`ifdef PUF_TIE_FLAG_EN
                    chk("tie_mask", tie_mask, m_tie & mask);
                    chk("tie_mask_cnt2", tie_mask2, m_tie2 & mask);
`endif
                    if (c < LAT) begin
                        bi = (c - 1) / PER;
                        p  = (c - 1) % PER;
                        chk("ro_en", ro_en, (p < S + W) ? 1 : 0);
                        chk("sel_a", sel_a, (m_ch + 2 * bi) % 32);
                        chk("sel_b", sel_b, (m_ch + 2 * bi + 1) % 32);
                        if (p == 0) obs_sel[bi] = sel_a;
                    end else begin
                        chk("ro_en_done", ro_en, 0);
                    end
                    if (done) begin
                        n_done++;
                        done_c = c;
                    end
                    if (c == LAT) begin
                        m_active    = 1'b0;
                        m_hold      = m_final;
                        m_hold2     = m_final2;
                        m_tie_hold  = m_tie;
                        m_tie_hold2 = m_tie2;
                    end
                end
            end else begin
                chk("idle_busy", busy, 0);
                chk("idle_done", done, 0);
                chk("idle_ro_en", ro_en, 0);
                chk("idle_response", response, m_hold);
                chk("idle_response_cnt2", response2, m_hold2);
`ifdef PUF_TIE_FLAG_EN
                chk("idle_tie_mask", tie_mask, m_tie_hold);
                chk("idle_tie_mask_cnt2", tie_mask2, m_tie_hold2);
`endif
                if (done) n_done++;
            end
        end
    end

    task automatic start_meas(input int ch, input int pa_i, input int pb_i);
        int ea, eb, ea2, eb2;
        @(negedge clk);
        pa = pa_i;
        pb = pb_i;
        repeat (4) @(negedge clk);
        ea  = edges(pa_i, 8);
        eb  = edges(pb_i, 8);
        ea2 = edges(pa_i, 2);
        eb2 = edges(pb_i, 2);
        for (int j = 0; j < RB; j++) begin
            m_final[j]  = (ea > eb);
            m_final2[j] = (ea2 > eb2);
            m_tie[j]    = (ea == eb);
            m_tie2[j]   = (ea2 == eb2);
        end
        for (int j = 0; j < RB; j++) obs_sel[j] = -1;
        done_c    = 0;
        m_ch      = ch;
        challenge = 5'(ch);
        start     = 1'b1;
        m_t0      = cyc;
        m_active  = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (m_active && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("done_wait_expired", m_active, 0);
        chk("done_cycle", done_c, LAT);
        repeat (3) @(negedge clk);
    endtask

    task automatic pin_sels(input int s0, input int s1, input int s2, input int s3);
        chk("pair0_sel_a", obs_sel[0], s0);
        chk("pair1_sel_a", obs_sel[1], s1);
        chk("pair2_sel_a", obs_sel[2], s2);
        chk("pair3_sel_a", obs_sel[3], s3);
    endtask

    initial begin
        int saved;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ro_en", ro_en, 0);
        chk("rst_sel_a", sel_a, 0);
        chk("rst_sel_b", sel_b, 0);
        chk("rst_response", response, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        saved = n_done;
        start_meas(3, 4, 8);
        wait_done();
        chk("fast_a_resp", response, 4'b1111);
        chk("fast_a_resp_cnt2", response2, 4'b1111);
        chk("fast_a_done_pulses", n_done - saved, 1);
        pin_sels(3, 5, 7, 9);

        start_meas(3, 8, 4);
        wait_done();
        chk("fast_b_resp", response, 4'b0000);

        start_meas(7, 4, 4);
        wait_done();
        chk("equal_resp", response, 4'b0000);
`ifdef PUF_TIE_FLAG_EN
        chk("equal_tie_mask", tie_mask, 4'b1111);
`endif

        start_meas(30, 4, 8);
        wait_done();
        pin_sels(30, 0, 2, 4);
        chk("wrap_last_sel_b", sel_b, 5);

        start_meas(0, 2, 4);
        wait_done();
        chk("sat_resp_cnt8", response, 4'b1111);
        chk("sat_resp_cnt2", response2, 4'b0000);

        saved = n_done;
        start_meas(3, 4, 8);
        repeat (30) @(negedge clk);
        challenge = 5'd12;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        chk("busy_start_done_pulses", n_done - saved, 1);
        chk("busy_start_resp", response, 4'b1111);
        pin_sels(3, 5, 7, 9);

        saved = n_done;
        start_meas(1, 8, 4);
        repeat (2 * PER + 5 - 1) @(negedge clk);
        chk("abort_cycle_ro_en", ro_en, 1);
        m_active = 1'b0;
        m_hold = '0; m_hold2 = '0; m_tie_hold = '0; m_tie_hold2 = '0;
        reset = 1'b1;
        #1;
        chk("abort_ro_en", ro_en, 0);
        chk("abort_response", response, 0);
        chk("abort_busy", busy, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_no_done", n_done - saved, 0);

        start_meas(1, 8, 4);
        wait_done();
        chk("after_abort_resp", response, 4'b0000);
        pin_sels(1, 3, 5, 7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
